// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes, the data-memory port and arbiter status.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_line;
    logic [DATA_W-1:0] mem_in;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_out;

    logic              busy;
    logic              last_grant;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_out,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_line, mem_in, mem_read, mem_write,
        output busy, last_grant
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_out,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_line, mem_in, mem_read, mem_write,
        input  busy, last_grant
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin sequencer for the single-port 128x8 data memory:
// one access in flight, registered one-cycle strobes, response after READ_LAT.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;
    localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_write;
    logic              r_busy;
    logic [1:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_mem_line;
    logic [DATA_W-1:0] r_mem_in;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp0_rdata;
    logic [DATA_W-1:0] r_rsp1_rdata;

    logic              w_idle;
    logic              w_grant;
    logic              w_accept;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_rsp_data;

    // On a tie, the requester that did not win last time goes next.
    // NOTE: selection is built from continuous assigns only, so no latch can be inferred.
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_accept = w_idle && (bus.req0_valid || bus.req1_valid);
    assign w_write  = w_grant ? bus.req1_write : bus.req0_write;
    assign w_addr   = w_grant ? bus.req1_addr  : bus.req0_addr;
    assign w_wdata  = w_grant ? bus.req1_wdata : bus.req0_wdata;

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept &&  w_grant;

    // Response is produced straight out of ACCESS for writes, out of the last WAIT cycle for reads.
    assign w_rsp_fire = ((r_state == S_ACCESS) && r_write) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == 2'd0));
    assign w_rsp_data = r_write ? '0 : bus.mem_out;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_wait_cnt   <= 2'd0;
            r_mem_line   <= '0;
            r_mem_in     <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_write      <= w_write;
                        r_mem_line   <= w_addr;
                        r_mem_in     <= w_wdata;
                        r_mem_write  <= w_write;
                        r_mem_read   <= !w_write;
                        r_busy       <= 1'b1;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_wait_cnt <= WAIT_INIT;
                    r_state    <= r_write ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_rsp_fire) begin
                r_rsp0_valid <= !r_owner;
                r_rsp1_valid <=  r_owner;
                if (r_owner) begin
                    r_rsp1_rdata <= w_rsp_data;
                end else begin
                    r_rsp0_rdata <= w_rsp_data;
                end
            end
        end
    end

    assign bus.mem_line   = r_mem_line;
    assign bus.mem_in     = r_mem_in;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = r_rsp0_rdata;
    assign bus.rsp1_rdata = r_rsp1_rdata;
    assign bus.busy       = r_busy;
    assign bus.last_grant = r_last_grant;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at READ_LAT=1 and one at READ_LAT=3,
// each backed by a small memory model whose read data appears READ_LAT cycles after the strobe.
module tb_dmem_arbiter;
    localparam int AW = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Memory models: read data shows 0 unless it was strobed exactly READ_LAT cycles ago.
    logic [DW-1:0] mem_a  [128] = '{default: '0};
    logic [DW-1:0] mem_b  [128] = '{default: '0};
    logic [DW-1:0] pipe_a [3]   = '{default: '0};
    logic [DW-1:0] pipe_b [3]   = '{default: '0};

    assign bus_a.mem_out = pipe_a[0];
    assign bus_b.mem_out = pipe_b[2];

    always @(posedge clk) begin
        if (bus_a.mem_write) mem_a[bus_a.mem_line] <= bus_a.mem_in;
        pipe_a[0] <= bus_a.mem_read ? mem_a[bus_a.mem_line] : '0;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        if (bus_b.mem_write) mem_b[bus_b.mem_line] <= bus_b.mem_in;
        pipe_b[0] <= bus_b.mem_read ? mem_b[bus_b.mem_line] : '0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    int n_overlap = 0;
    int n_rsp1_a  = 0;
    int n_line31  = 0;
    always @(negedge clk) begin
        if (bus_a.mem_read && bus_a.mem_write) n_overlap++;
        if (bus_b.mem_read && bus_b.mem_write) n_overlap++;
        if (bus_a.rsp1_valid) n_rsp1_a++;
        if ((bus_a.mem_read || bus_a.mem_write) && bus_a.mem_line == 7'h31) n_line31++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input bit who, input bit valid, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (who) begin
            bus_a.req1_valid = valid; bus_a.req1_write = wr;
            bus_a.req1_addr  = addr;  bus_a.req1_wdata = wd;
        end else begin
            bus_a.req0_valid = valid; bus_a.req0_write = wr;
            bus_a.req0_addr  = addr;  bus_a.req0_wdata = wd;
        end
    endtask

    // Full single-requester transaction on instance A with bounded waits.
    task automatic txn_a(input bit who, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd);
        int cnt = 0;
        req_a(who, 1'b1, wr, addr, wd);
        #1;
        while (!(who ? bus_a.req1_ready : bus_a.req0_ready) && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt >= 20) check("txn_ready_timeout", 1, 0);
        tick();
        req_a(who, 1'b0, 1'b0, '0, '0);
        cnt = 0;
        while (!(who ? bus_a.rsp1_valid : bus_a.rsp0_valid) && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt >= 20) check("txn_rsp_timeout", 1, 0);
        rd = who ? bus_a.rsp1_rdata : bus_a.rsp0_rdata;
        tick();
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            base;
        int            cnt;
        logic          grant;

        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        bus_b.req0_valid = 1'b0; bus_b.req0_write = 1'b0; bus_b.req0_addr = '0; bus_b.req0_wdata = '0;
        bus_b.req1_valid = 1'b0; bus_b.req1_write = 1'b0; bus_b.req1_addr = '0; bus_b.req1_wdata = '0;

        tick(); tick();
        rst = 1'b0;
        check("rst_busy",       bus_a.busy, 0);
        check("rst_last_grant", bus_a.last_grant, 1);
        check("rst_mem_line",   bus_a.mem_line, 0);
        check("rst_strobes",    {bus_a.mem_read, bus_a.mem_write}, 0);
        check("rst_rsp_valid",  {bus_a.rsp0_valid, bus_a.rsp1_valid}, 0);

        // 1: write 0x05 <= 0xA7 then read it back
        req_a(1'b0, 1'b1, 1'b1, 7'h05, 8'hA7);
        #1;
        check("t1_w_ready0", bus_a.req0_ready, 1);
        check("t1_w_ready1", bus_a.req1_ready, 0);
        tick();
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        check("t1_w_strobe", {bus_a.mem_write, bus_a.mem_read}, 2'b10);
        check("t1_w_line",   bus_a.mem_line, 7'h05);
        check("t1_w_in",     bus_a.mem_in, 8'hA7);
        check("t1_w_busy",   bus_a.busy, 1);
        tick();
        check("t1_w_rsp",    {bus_a.rsp0_valid, bus_a.rsp1_valid}, 2'b10);
        check("t1_w_strobe_off", {bus_a.mem_write, bus_a.mem_read}, 0);
        tick();
        check("t1_w_idle",   bus_a.busy, 0);
        check("t1_line_hold", bus_a.mem_line, 7'h05);

        req_a(1'b0, 1'b1, 1'b0, 7'h05, 8'h00);
        #1;
        check("t1_r_ready0", bus_a.req0_ready, 1);
        tick();
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        check("t1_r_strobe", {bus_a.mem_read, bus_a.mem_write}, 2'b10);
        tick();
        check("t1_r_wait",   {bus_a.mem_read, bus_a.rsp0_valid}, 0);
        tick();
        check("t1_r_rsp",    bus_a.rsp0_valid, 1);
        check("t1_r_rdata",  bus_a.rsp0_rdata, 8'hA7);
        tick();
        check("t1_r_pulse",  bus_a.rsp0_valid, 0);
        check("t1_r_hold",   bus_a.rsp0_rdata, 8'hA7);

        // preload for the arbitration tests
        txn_a(1'b1, 1'b1, 7'h10, 8'h5A, rd);
        txn_a(1'b0, 1'b1, 7'h11, 8'hC3, rd);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // 2: simultaneous reads after reset, requester 0 wins
        req_a(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
        req_a(1'b1, 1'b1, 1'b0, 7'h11, 8'h00);
        #1;
        check("t2_ready0", bus_a.req0_ready, 1);
        check("t2_ready1", bus_a.req1_ready, 0);
        tick();
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("t2_lg0", bus_a.last_grant, 0);
        check("t2_busy_ready1_a", bus_a.req1_ready, 0);
        tick();
        check("t2_busy_ready1_b", bus_a.req1_ready, 0);
        tick();
        check("t2_busy_ready1_c", bus_a.req1_ready, 0);
        check("t2_rsp0", {bus_a.rsp0_valid, bus_a.rsp1_valid}, 2'b10);
        check("t2_rdata0", bus_a.rsp0_rdata, 8'h5A);
        tick();
        check("t2_ready1_idle", bus_a.req1_ready, 1);
        tick();
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        check("t2_lg1", bus_a.last_grant, 1);
        tick(); tick();
        check("t2_rsp1", {bus_a.rsp0_valid, bus_a.rsp1_valid}, 2'b01);
        check("t2_rdata1", bus_a.rsp1_rdata, 8'hC3);
        tick();

        // 3: both valid continuously, six alternating grants
        req_a(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
        req_a(1'b1, 1'b1, 1'b0, 7'h11, 8'h00);
        #1;
        for (int k = 0; k < 6; k++) begin
            cnt = 0;
            while (!(bus_a.req0_ready || bus_a.req1_ready) && cnt < 20) begin
                tick();
                cnt++;
            end
            if (cnt >= 20) check("t3_ready_timeout", 1, 0);
            grant = bus_a.req1_ready;
            check("t3_grant", grant, k % 2);
            tick();
            check("t3_last_grant", bus_a.last_grant, k % 2);
            cnt = 0;
            while (!(bus_a.rsp0_valid || bus_a.rsp1_valid) && cnt < 20) begin
                tick();
                cnt++;
            end
            if (cnt >= 20) check("t3_rsp_timeout", 1, 0);
            check("t3_owner", {bus_a.rsp0_valid, bus_a.rsp1_valid}, (k % 2) ? 2'b01 : 2'b10);
            check("t3_rdata", (k % 2) ? bus_a.rsp1_rdata : bus_a.rsp0_rdata, (k % 2) ? 8'hC3 : 8'h5A);
            tick();
        end
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick(); tick();

        // 4: requester 1 pulses valid while busy and must leave no trace
        base = n_rsp1_a;
        req_a(1'b0, 1'b1, 1'b1, 7'h30, 8'h99);
        #1;
        check("t4_ready0", bus_a.req0_ready, 1);
        tick();
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        req_a(1'b1, 1'b1, 1'b1, 7'h31, 8'h66);
        #1;
        check("t4_ready1_busy", bus_a.req1_ready, 0);
        tick();
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        check("t4_w_rsp", bus_a.rsp0_valid, 1);
        check("t4_w_rdata_zero", bus_a.rsp0_rdata, 0);
        tick(); tick(); tick();
        check("t4_no_rsp1", n_rsp1_a - base, 0);
        check("t4_no_strobe31", n_line31, 0);
        check("t4_mem31", mem_a[7'h31], 0);
        txn_a(1'b0, 1'b0, 7'h30, 8'h00, rd);
        check("t4_readback", rd, 8'h99);

        // 5: reset in WAIT of a requester-1 read
        req_a(1'b1, 1'b1, 1'b0, 7'h40, 8'h00);
        #1;
        check("t5_ready1", bus_a.req1_ready, 1);
        tick();
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        check("t5_strobe", bus_a.mem_read, 1);
        tick();
        check("t5_in_wait", {bus_a.busy, bus_a.mem_read}, 2'b10);
        base = n_rsp1_a;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_strobes", {bus_a.mem_read, bus_a.mem_write}, 0);
        check("t5_busy", bus_a.busy, 0);
        check("t5_rsp1", bus_a.rsp1_valid, 0);
        check("t5_last_grant", bus_a.last_grant, 1);
        check("t5_line", bus_a.mem_line, 0);
        check("t5_rdata", {bus_a.rsp0_rdata, bus_a.rsp1_rdata}, 0);
        tick(); tick(); tick(); tick();
        check("t5_no_late_rsp", n_rsp1_a - base, 0);
        req_a(1'b0, 1'b1, 1'b0, 7'h10, 8'h00);
        req_a(1'b1, 1'b1, 1'b0, 7'h11, 8'h00);
        #1;
        check("t5_tie_ready", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
        tick();
        req_a(1'b0, 1'b0, 1'b0, '0, '0);
        req_a(1'b1, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick(); tick();

        // 6: READ_LAT = 3 instance
        bus_b.req0_valid = 1'b1; bus_b.req0_write = 1'b1;
        bus_b.req0_addr  = 7'h7F; bus_b.req0_wdata = 8'h3C;
        #1;
        check("t6_w_ready", bus_b.req0_ready, 1);
        tick();
        bus_b.req0_valid = 1'b0;
        check("t6_w_strobe", {bus_b.mem_write, bus_b.mem_line, bus_b.mem_in}, {1'b1, 7'h7F, 8'h3C});
        tick();
        check("t6_w_rsp", bus_b.rsp0_valid, 1);
        tick();
        bus_b.req0_valid = 1'b1; bus_b.req0_write = 1'b0;
        #1;
        check("t6_r_ready", bus_b.req0_ready, 1);
        tick();
        bus_b.req0_valid = 1'b0;
        check("t6_r_strobe", {bus_b.mem_read, bus_b.mem_line}, {1'b1, 7'h7F});
        for (int w = 0; w < 3; w++) begin
            tick();
            check("t6_wait", {bus_b.mem_read, bus_b.mem_write, bus_b.rsp0_valid, bus_b.mem_line},
                  {3'b000, 7'h7F});
        end
        tick();
        check("t6_r_rsp", bus_b.rsp0_valid, 1);
        check("t6_r_rdata", bus_b.rsp0_rdata, 8'h3C);
        tick();
        check("t6_idle", {bus_b.busy, bus_b.rsp0_valid}, 0);

        check("no_strobe_overlap", n_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
